cache_controller: RTL
=====================

// Module: cache_controller
// PURPOSE
//  Write-back, write-allocate FSM for a direct-mapped cache. Sequences the per-set data array
//  (byte-masked line write) and the tag/valid/dirty arrays. Sits between the CPU-facing port
//  (ufp_*, one 32-bit word) and the memory-facing port (dfp_*, one full line). Serves one
//  request at a time: hits, clean misses (allocate) and dirty misses (writeback, then allocate).
// PARAMETERS
//  s_offset  5                       line byte-offset bits (32 B line)
//  s_index   4                       set index bits (16 sets)
//  s_tag     32-s_offset-s_index     tag width
//  s_mask    2**s_offset             bytes per line = data-array write-enable width
//  s_line    8*s_mask                line width in bits
// PORTS
//  clk         in   1         clock, rising edge
//  rst_n       in   1         asynchronous, active-low reset
//  ufp_addr    in   32        CPU byte address; [1:0] ignored (word aligned)
//  ufp_rmask   in   4         byte read mask; nonzero = read request
//  ufp_wmask   in   4         byte write mask; nonzero = write request
//  ufp_wdata   in   32        CPU write data
//  ufp_rdata   out  32        read data; valid only while ufp_resp=1
//  ufp_resp    out  1         one-cycle completion pulse
//  dfp_addr    out  32        line address, [s_offset-1:0]=0
//  dfp_read    out  1         line fill request; held until dfp_resp
//  dfp_write   out  1         line writeback request; held until dfp_resp
//  dfp_wdata   out  s_line    writeback line (= arr_data_out)
//  dfp_rdata   in   s_line    fill line
//  dfp_resp    in   1         memory completion, one cycle
//  arr_index   out  s_index   set index to all arrays
//  data_we     out  s_mask    per-byte data-array write enable
//  data_in     out  s_line    data-array write line
//  arr_data_out in  s_line    data-array read line (combinational in arr_index)
//  tag_out     in   s_tag     stored tag for arr_index
//  valid_out   in   1         stored valid bit
//  dirty_out   in   1         stored dirty bit
//  meta_we     out  1         write tag/valid/dirty this cycle
//  tag_in / valid_in / dirty_in  out  s_tag/1/1   metadata write values
// BEHAVIOUR
//  Reset: state=IDLE, request latches cleared; ufp_resp, dfp_read, dfp_write, data_we, meta_we = 0;
//   all other outputs 0. Arrays are reset by their own modules.
//  Requester holds ufp_* stable until ufp_resp. Requests arriving in non-IDLE states are ignored.
//  IDLE: arr_index = ufp_addr index field. If rmask|wmask != 0, latch addr, masks, wdata -> COMPARE.
//   If both masks are nonzero, the request is a write (wmask wins, rmask dropped).
//  COMPARE: arr_index = latched index; hit = valid_out & (tag_out == latched tag).
//   Read hit: ufp_resp=1, ufp_rdata = word[addr[s_offset-1:2]] of arr_data_out -> IDLE.
//   Write hit: data_we = wmask << (4*word), data_in = wdata replicated s_mask/4 times,
//    meta_we=1 (tag kept, valid=1, dirty=1), ufp_resp=1 -> IDLE.
//   Miss & valid & dirty -> WRITEBACK; other misses -> ALLOCATE.
//  WRITEBACK: dfp_write=1, dfp_addr={tag_out,index,0}, dfp_wdata=arr_data_out;
//   on dfp_resp -> ALLOCATE.
//  ALLOCATE: dfp_read=1, dfp_addr={latched tag,index,0}; on dfp_resp: data_we='1,
//   data_in=dfp_rdata, meta_we=1 (tag_in=latched tag, valid=1, dirty=0) -> COMPARE
//   (the re-compare then hits).
//  Hit latency: 2 cycles from request accept to ufp_resp. dfp_resp in IDLE/COMPARE is ignored.
//  dfp_read and dfp_write are never high together. rst_n low in any state aborts the transaction:
//   dfp_* requests drop asynchronously and a late dfp_resp after reset is ignored.
// STRUCTURE
//  cache_pkg: state enum {IDLE,COMPARE,WRITEBACK,ALLOCATE}; address field-slice functions
//   (tag/index/word) parameterised on s_offset/s_index.
//  FSM and datapath muxing stay inline. One optional sub-module, cache_word_sel: word extraction
//   and write-mask/data alignment.
// TESTING
//  1 Reset, then read 0x0000_1004 rmask=F (cold miss) -> dfp_read, dfp_addr=0x0000_1000; return a
//    line with word1=0xDEADBEEF after 3 cycles -> data_we='1, then ufp_resp with ufp_rdata=0xDEADBEEF.
//  2 Write 0x0000_1008 wmask=0011 wdata=0x0000_ABCD (hit) -> data_we=0x0000_0300, dirty_in=1,
//    ufp_resp 2 cycles after accept; then read the same address -> ufp_rdata[15:0]=0xABCD.
//  3 Read 0x0000_1208 (same set 0, dirty) -> dfp_write, dfp_addr=0x0000_1000, old line on dfp_wdata;
//    after dfp_resp -> dfp_read at 0x0000_1200, never both asserted.
//  4 rst_n low mid-ALLOCATE -> dfp_read=0 immediately, state IDLE; dfp_resp pulse after release
//    -> no ufp_resp, no array write.
//  5 rmask=F and wmask=1 together on a hit -> treated as a write: data_we nonzero, dirty set.
//  6 Back-to-back read hits -> each ufp_resp exactly 2 cycles after accept; a stray dfp_resp in
//    IDLE has no effect.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the
// direct-mapped write-back cache controller.
package cache_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 4;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_MASK   = 2 ** S_OFFSET;
  localparam int S_LINE   = 8 * S_MASK;
  localparam int S_WORD   = S_OFFSET - 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_e;

  function automatic logic [S_TAG-1:0] addr_tag(input logic [31:0] addr);
    return S_TAG'(addr >> (S_OFFSET + S_INDEX));
  endfunction

  function automatic logic [S_INDEX-1:0] addr_index(input logic [31:0] addr);
    return S_INDEX'(addr >> S_OFFSET);
  endfunction

  function automatic logic [S_WORD-1:0] addr_word(input logic [31:0] addr);
    return S_WORD'(addr >> 2);
  endfunction

endpackage

// File: rtl/cache_word_sel.sv
// Word extraction from a cache line and alignment of a CPU word write
// (byte enables and replicated data) into line position.
module cache_word_sel
  import cache_pkg::*;
(
  input  logic [S_LINE-1:0] line_i,
  input  logic [S_WORD-1:0] word_i,
  input  logic [3:0]        wmask_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rword_o,
  output logic [S_MASK-1:0] we_o,
  output logic [S_LINE-1:0] wline_o
);

  assign rword_o = line_i[32*word_i +: 32];
  assign we_o    = S_MASK'(wmask_i) << (4 * word_i);
  assign wline_o = {(S_MASK/4){wdata_i}};

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped cache: hits,
// clean misses (allocate) and dirty misses (writeback then allocate).
module cache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        ufp_addr,
  input  logic [3:0]         ufp_rmask,
  input  logic [3:0]         ufp_wmask,
  input  logic [31:0]        ufp_wdata,
  output logic [31:0]        ufp_rdata,
  output logic               ufp_resp,
  output logic [31:0]        dfp_addr,
  output logic               dfp_read,
  output logic               dfp_write,
  output logic [S_LINE-1:0]  dfp_wdata,
  input  logic [S_LINE-1:0]  dfp_rdata,
  input  logic               dfp_resp,
  output logic [S_INDEX-1:0] arr_index,
  output logic [S_MASK-1:0]  data_we,
  output logic [S_LINE-1:0]  data_in,
  input  logic [S_LINE-1:0]  arr_data_out,
  input  logic [S_TAG-1:0]   tag_out,
  input  logic               valid_out,
  input  logic               dirty_out,
  output logic               meta_we,
  output logic [S_TAG-1:0]   tag_in,
  output logic               valid_in,
  output logic               dirty_in
);

  cache_state_e        state_q;
  logic [S_TAG-1:0]    tag_q;
  logic [S_INDEX-1:0]  index_q;
  logic [S_WORD-1:0]   word_q;
  logic [3:0]          wmask_q;
  logic [31:0]         wdata_q;
  logic                resp_q;
  logic [31:0]         rdata_q;
  logic                dfp_read_q;
  logic                dfp_write_q;
  logic [31:0]         dfp_addr_q;

  logic                hit;
  logic                accept;
  logic [31:0]         sel_word;
  logic [S_MASK-1:0]   sel_we;
  logic [S_LINE-1:0]   sel_line;

  cache_word_sel u_word_sel (
    .line_i  (arr_data_out),
    .word_i  (word_q),
    .wmask_i (wmask_q),
    .wdata_i (wdata_q),
    .rword_o (sel_word),
    .we_o    (sel_we),
    .wline_o (sel_line)
  );

  // The response pulse is registered, so the requester still drives its old
  // request during the pulse cycle; that cycle must not be accepted again.
  assign accept = (state_q == IDLE) && !resp_q && ((ufp_rmask | ufp_wmask) != 4'b0);
  assign hit    = valid_out && (tag_out == tag_q);

  assign ufp_resp  = resp_q;
  assign ufp_rdata = rdata_q;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign dfp_addr  = dfp_addr_q;
  assign dfp_wdata = arr_data_out;

  always_comb begin
    arr_index = index_q;
    data_we   = '0;
    data_in   = '0;
    meta_we   = 1'b0;
    tag_in    = tag_q;
    valid_in  = 1'b0;
    dirty_in  = 1'b0;
    unique case (state_q)
      IDLE: arr_index = addr_index(ufp_addr);
      COMPARE: begin
        if (hit && (wmask_q != 4'b0)) begin
          data_we  = sel_we;
          data_in  = sel_line;
          meta_we  = 1'b1;
          valid_in = 1'b1;
          dirty_in = 1'b1;
        end
      end
      ALLOCATE: begin
        if (dfp_resp) begin
          data_we  = '1;
          data_in  = dfp_rdata;
          meta_we  = 1'b1;
          valid_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      word_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      dfp_addr_q  <= '0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q   <= addr_tag(ufp_addr);
            index_q <= addr_index(ufp_addr);
            word_q  <= addr_word(ufp_addr);
            wmask_q <= ufp_wmask;
            wdata_q <= ufp_wdata;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            resp_q  <= 1'b1;
            rdata_q <= sel_word;
            state_q <= IDLE;
          end else if (valid_out && dirty_out) begin
            dfp_write_q <= 1'b1;
            dfp_addr_q  <= {tag_out, index_q, {S_OFFSET{1'b0}}};
            state_q     <= WRITEBACK;
          end else begin
            dfp_read_q <= 1'b1;
            dfp_addr_q <= {tag_q, index_q, {S_OFFSET{1'b0}}};
            state_q    <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (dfp_resp) begin
            dfp_write_q <= 1'b0;
            dfp_read_q  <= 1'b1;
            dfp_addr_q  <= {tag_q, index_q, {S_OFFSET{1'b0}}};
            state_q     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (dfp_resp) begin
            dfp_read_q <= 1'b0;
            dfp_addr_q <= '0;
            state_q    <= COMPARE;
          end
        end
      endcase
    end
  end

endmodule
